// File: rtl/avalon_lag_reader.sv
// avalon_lag_reader: Avalon-MM read master that polls the CPU lag peripheral.
// Each poll reads word 0 (packed lags, shoot, enable) and publishes it on
// registered outputs with a one-cycle valid pulse and a change flag.
// Optional feature macro DEBUG_READ_EN: each poll also reads word 1 (debug
// word). Without it only word 0 is read and the debug outputs are tied to 0.
module avalon_lag_reader #(
    parameter int NUM_XCORRS     = 6,
    parameter int BITS_PER_XCORR = 5,
    parameter int POLL_PERIOD    = 1000,
    parameter int TIMEOUT        = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        poll_en,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    output logic [29:0] lags,
    output logic        shoot,
    output logic        enable_flag,
    output logic        lags_valid,
    output logic        lags_changed,
    output logic [31:0] debug_word,
    output logic        debug_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam int LAG_W  = NUM_XCORRS * BITS_PER_XCORR;
    localparam int PCNT_W = $clog2(POLL_PERIOD + 1);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    localparam logic [PCNT_W-1:0] P_LAST   = PCNT_W'(POLL_PERIOD - 1);
    localparam logic [TCNT_W-1:0] T_MAX    = TCNT_W'(TIMEOUT);
    localparam logic [29:0]       LAG_MASK = 30'((64'd1 << LAG_W) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_REQ0  = 3'd2,
        S_DATA0 = 3'd3,
        S_REQ1  = 3'd4,
        S_DATA1 = 3'd5
    } state_t;

`ifdef DEBUG_READ_EN
    localparam state_t NEXT0 = S_REQ1;
`else
    localparam state_t NEXT0 = S_WAIT;
`endif

    state_t              state_q;
    state_t              state_d;
    logic [PCNT_W-1:0]   pcnt_q;
    logic [TCNT_W-1:0]   tcnt_q;
    logic                tmo_hit;
    logic                tmo;
    logic                cap0;
    logic [31:0]         word_p0;

    assign tmo_hit = (tcnt_q == T_MAX);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef DEBUG_READ_EN
    logic        cap1;
    logic [31:0] dbg_p0;

    // Next-state logic, including the debug-word read phases
    always_comb begin
        state_d = state_q;
        cap0    = 1'b0;
        cap1    = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            S_IDLE:  if (poll_en) state_d = S_REQ0;
            S_WAIT: begin
                if (!poll_en)              state_d = S_IDLE;
                else if (pcnt_q == P_LAST) state_d = S_REQ0;
            end
            S_REQ0: begin
                if (tmo_hit) begin
                    tmo     = 1'b1;
                    state_d = S_WAIT;
                end else if (!avm_waitrequest) begin
                    if (avm_readdatavalid) begin
                        cap0    = 1'b1;
                        state_d = NEXT0;
                    end else begin
                        state_d = S_DATA0;
                    end
                end
            end
            S_DATA0: begin
                if (tmo_hit) begin
                    tmo     = 1'b1;
                    state_d = S_WAIT;
                end else if (avm_readdatavalid) begin
                    cap0    = 1'b1;
                    state_d = NEXT0;
                end
            end
            S_REQ1: begin
                if (tmo_hit) begin
                    tmo     = 1'b1;
                    state_d = S_WAIT;
                end else if (!avm_waitrequest) begin
                    if (avm_readdatavalid) begin
                        cap1    = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_DATA1;
                    end
                end
            end
            S_DATA1: begin
                if (tmo_hit) begin
                    tmo     = 1'b1;
                    state_d = S_WAIT;
                end else if (avm_readdatavalid) begin
                    cap1    = 1'b1;
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Debug word capture and its one-cycle valid pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbg_p0      <= '0;
            debug_valid <= 1'b0;
        end else begin
            debug_valid <= cap1;
            if (cap1) dbg_p0 <= avm_readdata;
        end
    end

    assign debug_word = dbg_p0;
`else
    // Next-state logic, lag word only
    always_comb begin
        state_d = state_q;
        cap0    = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            S_IDLE:  if (poll_en) state_d = S_REQ0;
            S_WAIT: begin
                if (!poll_en)              state_d = S_IDLE;
                else if (pcnt_q == P_LAST) state_d = S_REQ0;
            end
            S_REQ0: begin
                if (tmo_hit) begin
                    tmo     = 1'b1;
                    state_d = S_WAIT;
                end else if (!avm_waitrequest) begin
                    if (avm_readdatavalid) begin
                        cap0    = 1'b1;
                        state_d = NEXT0;
                    end else begin
                        state_d = S_DATA0;
                    end
                end
            end
            S_DATA0: begin
                if (tmo_hit) begin
                    tmo     = 1'b1;
                    state_d = S_WAIT;
                end else if (avm_readdatavalid) begin
                    cap0    = 1'b1;
                    state_d = NEXT0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign debug_word  = 32'd0;
    assign debug_valid = 1'b0;
`endif

    // Bus outputs and busy decoded from the current state
    always_comb begin
        avm_read    = 1'b0;
        avm_address = 1'b0;
        busy        = 1'b1;
        case (state_q)
            S_IDLE, S_WAIT: busy = 1'b0;
            S_REQ0:         avm_read = 1'b1;
`ifdef DEBUG_READ_EN
            S_REQ1: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Poll period counter: runs only while staying in WAIT, saturates at terminal
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q <= '0;
        end else if (state_q == S_WAIT && state_d == S_WAIT) begin
            if (pcnt_q != P_LAST) pcnt_q <= pcnt_q + PCNT_W'(1);
        end else begin
            pcnt_q <= '0;
        end
    end

    // Bus-phase timeout counter: cleared on every state change, saturating
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt_q <= '0;
        end else if (state_d != state_q) begin
            tcnt_q <= '0;
        end else if (busy && tcnt_q != T_MAX) begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
        end
    end

    // Lag word capture, valid/changed pulses and sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_p0      <= '0;
            lags_valid   <= 1'b0;
            lags_changed <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            lags_valid   <= cap0;
            lags_changed <= cap0 && (avm_readdata != word_p0);
            if (cap0) word_p0    <= avm_readdata;
            if (tmo)  timeout_err <= 1'b1;
        end
    end

    assign lags        = word_p0[29:0] & LAG_MASK;
    assign shoot       = word_p0[30];
    assign enable_flag = word_p0[31];

endmodule
